// File: rtl/rf_wb_queue.sv
// Writeback queue between the ALU/LSU result producers and the register file's single write port.
// Optional define WB_BYPASS_EN adds youngest-match data forwarding for the two decode sources.
module rf_wb_queue #(
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 5,
    parameter int DEPTH       = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [INDEX_WIDTH-1:0]       alu_index,
    input  logic [DATA_WIDTH-1:0]        alu_data,
    input  logic                         lsu_valid,
    output logic                         lsu_ready,
    input  logic [INDEX_WIDTH-1:0]       lsu_index,
    input  logic [DATA_WIDTH-1:0]        lsu_data,
    input  logic                         rf_wr_stall,
    output logic                         rf1_wr_en,
    output logic [INDEX_WIDTH-1:0]       rf1_wr_index,
    output logic [DATA_WIDTH-1:0]        rf1_wr_data,
    input  logic [INDEX_WIDTH-1:0]       rd_index1,
    input  logic [INDEX_WIDTH-1:0]       rd_index2,
    output logic                         busy1,
    output logic                         busy2,
    output logic                         fwd_valid1,
    output logic                         fwd_valid2,
    output logic [DATA_WIDTH-1:0]        fwd_data1,
    output logic [DATA_WIDTH-1:0]        fwd_data2,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        RR_ALU = 1'b0,
        RR_LSU = 1'b1
    } rr_t;

    logic [INDEX_WIDTH-1:0] entry_index [DEPTH];
    logic [DATA_WIDTH-1:0]  entry_data  [DEPTH];
    logic [DEPTH-1:0]       entry_valid;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    rr_t                    rr;

    logic                   full;
    logic                   empty;
    logic                   grant_any;
    logic                   push;
    logic                   pop;
    logic [INDEX_WIDTH-1:0] push_index;
    logic [DATA_WIDTH-1:0]  push_data;

    // Handshake: a producer transfers on any edge where its valid and ready are both high;
    // ready depends only on registered state and the two valid inputs, never the reverse.
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    assign alu_ready = !full && alu_valid && (!lsu_valid || rr == RR_ALU);
    assign lsu_ready = !full && lsu_valid && (!alu_valid || rr == RR_LSU);
    assign grant_any = alu_ready || lsu_ready;

    assign push_index = alu_ready ? alu_index : lsu_index;
    assign push_data  = alu_ready ? alu_data  : lsu_data;

    // Writes to x0 are acknowledged but dropped; the register is hard-wired to zero.
    assign push = grant_any && (push_index != '0);
    assign pop  = rf1_wr_en;

    assign rf1_wr_en    = !empty && !rf_wr_stall;
    assign rf1_wr_index = entry_index[rd_ptr];
    assign rf1_wr_data  = entry_data[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
            rr          <= RR_ALU;
        end else begin
            if (pop) begin
                entry_valid[rd_ptr] <= 1'b0;
                rd_ptr              <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                entry_valid[wr_ptr] <= 1'b1;
                wr_ptr              <= wr_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (alu_valid && lsu_valid && grant_any) begin
                rr <= (rr == RR_ALU) ? RR_LSU : RR_ALU;
            end
        end
    end

    // Payload storage carries no reset; the valid bits alone define occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_index[wr_ptr] <= push_index;
            entry_data[wr_ptr]  <= push_data;
        end
    end

    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && entry_index[i] == rd_index1 && rd_index1 != '0) begin
                busy1 = 1'b1;
            end
            if (entry_valid[i] && entry_index[i] == rd_index2 && rd_index2 != '0) begin
                busy2 = 1'b1;
            end
        end
    end

`ifdef WB_BYPASS_EN
    // Walk from the head towards the tail so the last match seen is the youngest write.
    always_comb begin
        logic [PTR_W-1:0] pos;
        fwd_data1 = '0;
        fwd_data2 = '0;
        pos       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pos = rd_ptr + PTR_W'(i);
            if (entry_valid[pos] && entry_index[pos] == rd_index1 && rd_index1 != '0) begin
                fwd_data1 = entry_data[pos];
            end
            if (entry_valid[pos] && entry_index[pos] == rd_index2 && rd_index2 != '0) begin
                fwd_data2 = entry_data[pos];
            end
        end
    end

    assign fwd_valid1 = busy1;
    assign fwd_valid2 = busy2;
`else
    assign fwd_valid1 = 1'b0;
    assign fwd_valid2 = 1'b0;
    assign fwd_data1  = '0;
    assign fwd_data2  = '0;
`endif

endmodule

// File: tb/tb_rf_wb_queue.sv
// Directed bench for rf_wb_queue: expected register-file writes are queued at each accepted
// handshake and compared in order whenever the write port fires.
module tb_rf_wb_queue;

    localparam int DW = 32;
    localparam int IW = 5;
    localparam int DEPTH = 4;
    localparam int CW = 3;
    localparam int EW = IW + DW;

    logic          clk;
    logic          reset;
    logic          alu_valid;
    logic          alu_ready;
    logic [IW-1:0] alu_index;
    logic [DW-1:0] alu_data;
    logic          lsu_valid;
    logic          lsu_ready;
    logic [IW-1:0] lsu_index;
    logic [DW-1:0] lsu_data;
    logic          rf_wr_stall;
    logic          rf1_wr_en;
    logic [IW-1:0] rf1_wr_index;
    logic [DW-1:0] rf1_wr_data;
    logic [IW-1:0] rd_index1;
    logic [IW-1:0] rd_index2;
    logic          busy1;
    logic          busy2;
    logic          fwd_valid1;
    logic          fwd_valid2;
    logic [DW-1:0] fwd_data1;
    logic [DW-1:0] fwd_data2;
    logic [CW-1:0] count;

    int checks = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;

    rf_wb_queue #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_index    (alu_index),
        .alu_data     (alu_data),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_index    (lsu_index),
        .lsu_data     (lsu_data),
        .rf_wr_stall  (rf_wr_stall),
        .rf1_wr_en    (rf1_wr_en),
        .rf1_wr_index (rf1_wr_index),
        .rf1_wr_data  (rf1_wr_data),
        .rd_index1    (rd_index1),
        .rd_index2    (rd_index2),
        .busy1        (busy1),
        .busy2        (busy2),
        .fwd_valid1   (fwd_valid1),
        .fwd_valid2   (fwd_valid2),
        .fwd_data1    (fwd_data1),
        .fwd_data2    (fwd_data2),
        .count        (count)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 20; n++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: every write-port cycle must match the oldest expected entry
    always @(negedge clk) begin
        if (reset && rf1_wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_index", 64'(rf1_wr_index), 64'(mon_e[EW-1:DW]));
                check("wr_data", 64'(rf1_wr_data), 64'(mon_e[DW-1:0]));
            end
        end
    end

    initial begin
        int ai;
        int li;
        logic rr_m;
        logic ga;
        logic gl;

        reset = 1'b0;
        alu_valid = 1'b0; alu_index = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_index = '0; lsu_data = '0;
        rf_wr_stall = 1'b0;
        rd_index1 = '0; rd_index2 = '0;

        // Reset state
        #2;
        check("rst_count", 64'(count), 64'd0);
        check("rst_wr_en", 64'(rf1_wr_en), 64'd0);
        check("rst_busy", 64'({busy1, busy2}), 64'd0);
        check("rst_fwd_valid", 64'({fwd_valid1, fwd_valid2}), 64'd0);
        check("rst_fwd_data", 64'({fwd_data1, fwd_data2}), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        tick();

        // Single write with hazard visibility
        alu_valid = 1'b1; alu_index = 5'd5; alu_data = 32'hDEADBEEF;
        rd_index1 = 5'd5;
        @(negedge clk);
        check("single_ready", 64'(alu_ready), 64'd1);
        check("single_busy_pre", 64'(busy1), 64'd0);
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        tick();
        alu_valid = 1'b0;
        @(negedge clk);
        check("single_wr_en", 64'(rf1_wr_en), 64'd1);
        check("single_wr_index", 64'(rf1_wr_index), 64'd5);
        check("single_count1", 64'(count), 64'd1);
        check("single_busy1", 64'(busy1), 64'd1);
        tick();
        @(negedge clk);
        check("single_count0", 64'(count), 64'd0);
        check("single_busy_clr", 64'(busy1), 64'd0);
        check("single_idle", 64'(rf1_wr_en), 64'd0);
        rd_index1 = '0;
        tick();

        // Contention: ALU offers 1,3,5 and LSU offers 2,4,6
        ai = 0; li = 0; rr_m = 1'b0;
        for (int c = 0; c < 6; c++) begin
            alu_valid = (ai < 3);
            alu_index = IW'(1 + 2 * ai);
            alu_data  = 32'hC000_0000 + DW'(1 + 2 * ai);
            lsu_valid = (li < 3);
            lsu_index = IW'(2 + 2 * li);
            lsu_data  = 32'hC000_0000 + DW'(2 + 2 * li);
            @(negedge clk);
            ga = alu_valid && (!lsu_valid || !rr_m);
            gl = lsu_valid && (!alu_valid || rr_m);
            check($sformatf("rr_alu_ready_c%0d", c), 64'(alu_ready), 64'(ga));
            check($sformatf("rr_lsu_ready_c%0d", c), 64'(lsu_ready), 64'(gl));
            if (ga) begin
                exp_q.push_back({alu_index, alu_data});
                ai++;
            end
            if (gl) begin
                exp_q.push_back({lsu_index, lsu_data});
                li++;
            end
            if (alu_valid && lsu_valid) rr_m = ~rr_m;
            tick();
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        drain("rr_drain");

        // Full under stall, then release
        rf_wr_stall = 1'b1;
        alu_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alu_index = IW'(8 + i);
            alu_data  = 32'hF000_0000 + DW'(i);
            @(negedge clk);
            check($sformatf("full_accept_%0d", i), 64'(alu_ready), 64'd1);
            exp_q.push_back({alu_index, alu_data});
            tick();
        end
        alu_index = 5'd12; alu_data = 32'hF000_0004;
        @(negedge clk);
        check("full_count", 64'(count), 64'd4);
        check("full_ready", 64'(alu_ready), 64'd0);
        check("full_stalled", 64'(rf1_wr_en), 64'd0);
        tick();
        rf_wr_stall = 1'b0;
        @(negedge clk);
        check("full_no_passthru", 64'(alu_ready), 64'd0);
        check("full_release_wr", 64'(rf1_wr_en), 64'd1);
        tick();
        @(negedge clk);
        check("full_count3", 64'(count), 64'd3);
        check("full_fifth_ready", 64'(alu_ready), 64'd1);
        check("full_consec_wr", 64'(rf1_wr_en), 64'd1);
        exp_q.push_back({5'd12, 32'hF000_0004});
        tick();
        alu_valid = 1'b0;
        @(negedge clk);
        check("full_pushpop_count", 64'(count), 64'd3);
        drain("full_drain");

        // Write to x0 is acknowledged and dropped
        lsu_valid = 1'b1; lsu_index = 5'd0; lsu_data = 32'h0000_00FF;
        rd_index1 = 5'd0;
        @(negedge clk);
        check("x0_ready", 64'(lsu_ready), 64'd1);
        tick();
        lsu_valid = 1'b0;
        @(negedge clk);
        check("x0_count", 64'(count), 64'd0);
        check("x0_wr_en", 64'(rf1_wr_en), 64'd0);
        check("x0_busy", 64'(busy1), 64'd0);
        tick();

        // Asynchronous reset with queued entries
        rf_wr_stall = 1'b1;
        alu_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_index = IW'(13 + i);
            alu_data  = 32'hBAD0_0000 + DW'(i);
            @(negedge clk);
            check($sformatf("rst_fill_%0d", i), 64'(alu_ready), 64'd1);
            tick();
        end
        alu_valid = 1'b0;
        rd_index1 = 5'd13;
        @(negedge clk);
        check("rst_fill_count", 64'(count), 64'd3);
        check("rst_fill_busy", 64'(busy1), 64'd1);
        #1;
        rf_wr_stall = 1'b0;
        reset = 1'b0;
        #1;
        check("async_rst_count", 64'(count), 64'd0);
        check("async_rst_wr_en", 64'(rf1_wr_en), 64'd0);
        check("async_rst_busy", 64'(busy1), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        rd_index1 = '0;
        repeat (4) tick();
        check("post_rst_count", 64'(count), 64'd0);

        // Round-robin pointer returns to ALU after reset
        alu_valid = 1'b1; alu_index = 5'd9;  alu_data = 32'h0000_0099;
        lsu_valid = 1'b1; lsu_index = 5'd10; lsu_data = 32'h0000_00AA;
        @(negedge clk);
        check("post_rst_alu_first", 64'({alu_ready, lsu_ready}), 64'b10);
        exp_q.push_back({5'd9, 32'h0000_0099});
        tick();
        alu_valid = 1'b0;
        @(negedge clk);
        check("post_rst_lsu_next", 64'(lsu_ready), 64'd1);
        exp_q.push_back({5'd10, 32'h0000_00AA});
        tick();
        lsu_valid = 1'b0;
        drain("post_rst_drain");

        // Forwarding of the youngest matching entry
        rf_wr_stall = 1'b1;
        alu_valid = 1'b1; alu_index = 5'd7; alu_data = 32'h11;
        @(negedge clk);
        exp_q.push_back({5'd7, 32'h11});
        tick();
        alu_data = 32'h22;
        @(negedge clk);
        exp_q.push_back({5'd7, 32'h22});
        tick();
        alu_valid = 1'b0;
        rd_index2 = 5'd7;
        rd_index1 = 5'd3;
        @(negedge clk);
        check("byp_busy2", 64'(busy2), 64'd1);
        check("byp_busy1_miss", 64'(busy1), 64'd0);
`ifdef WB_BYPASS_EN
        check("byp_fwd_valid2", 64'(fwd_valid2), 64'd1);
        check("byp_fwd_data2", 64'(fwd_data2), 64'h22);
        check("byp_fwd_valid1", 64'(fwd_valid1), 64'd0);
`else
        check("byp_fwd_valid2_off", 64'(fwd_valid2), 64'd0);
        check("byp_fwd_data2_off", 64'(fwd_data2), 64'd0);
`endif
        tick();
        rf_wr_stall = 1'b0;
        @(negedge clk);
        check("byp_head_busy", 64'(busy2), 64'd1);
        tick();
        @(negedge clk);
        check("byp_tail_busy", 64'(busy2), 64'd1);
`ifdef WB_BYPASS_EN
        check("byp_tail_data", 64'(fwd_data2), 64'h22);
`endif
        tick();
        @(negedge clk);
        check("byp_clear", 64'(busy2), 64'd0);
        rd_index2 = '0;
        drain("final_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
